// File: rtl/matrix_load_sequencer.sv
// Routes MEM-stage matrix element loads into the A/B operand buffers, starts the
// matrix unit once both buffers are full, and stalls the pipeline while it computes.
module matrix_load_sequencer #(
  parameter  int DIM    = 4,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(DIM*DIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_load_a_en,
  input  logic              mem_load_b_en,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              mtx_done,
  output logic              buf_a_we,
  output logic              buf_b_we,
  output logic [AW-1:0]     buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              mtx_start,
  output logic              pipe_stall,
  output logic              busy,
  output logic              seq_err
);

  localparam logic [AW-1:0] LAST = AW'(DIM*DIM-1);

  typedef enum logic [1:0] {IDLE, START, COMPUTE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] cnt_a, cnt_b;
  logic          a_full, b_full;
  logic          load_a, load_b, err_set, clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    err_set    = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (a_full && b_full) state_next = START;
        if (mem_load_a_en && mem_load_b_en) begin
          err_set = 1'b1;
        end else if (mem_load_a_en) begin
          if (a_full) err_set = 1'b1;
          else        load_a  = 1'b1;
        end else if (mem_load_b_en) begin
          if (b_full) err_set = 1'b1;
          else        load_b  = 1'b1;
        end
      end
      START: state_next = COMPUTE;
      COMPUTE: begin
        if (mtx_done) begin
          state_next = IDLE;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Loads seen outside IDLE are frozen in EX/MEM and retried once back in IDLE.
  assign pipe_stall = (state != IDLE) && (mem_load_a_en || mem_load_b_en);

  // Start and busy are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_a_we  <= 1'b0;
      buf_b_we  <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      mtx_start <= 1'b0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      a_full    <= 1'b0;
      b_full    <= 1'b0;
    end else begin
      buf_a_we  <= load_a;
      buf_b_we  <= load_b;
      mtx_start <= (state_next == START);
      busy      <= (state_next != IDLE);
      if (err_set) seq_err <= 1'b1;
      if (load_a) begin
        buf_addr  <= cnt_a;
        buf_wdata <= mem_load_data;
        if (cnt_a == LAST) begin
          cnt_a  <= '0;
          a_full <= 1'b1;
        end else begin
          cnt_a <= cnt_a + 1'b1;
        end
      end
      if (load_b) begin
        buf_addr  <= cnt_b;
        buf_wdata <= mem_load_data;
        if (cnt_b == LAST) begin
          cnt_b  <= '0;
          b_full <= 1'b1;
        end else begin
          cnt_b <= cnt_b + 1'b1;
        end
      end
      if (clear) begin
        cnt_a  <= '0;
        cnt_b  <= '0;
        a_full <= 1'b0;
        b_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: element-count model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_matrix_load_sequencer;

  localparam int DIM    = 4;
  localparam int DATA_W = 32;
  localparam int N      = DIM*DIM;
  localparam int AW     = $clog2(N);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_en = 1'b0, b_en = 1'b0, done = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              buf_a_we, buf_b_we, mtx_start, pipe_stall, busy, seq_err;
  logic [AW-1:0]     buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  matrix_load_sequencer #(.DIM(DIM), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .mem_load_a_en(a_en), .mem_load_b_en(b_en), .mem_load_data(data),
    .mtx_done(done),
    .buf_a_we(buf_a_we), .buf_b_we(buf_b_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .mtx_start(mtx_start), .pipe_stall(pipe_stall), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: how many elements each buffer holds, and which phase the unit is in
  // (0 filling, 1 start cycle, 2 computing).
  int   na, nb, phase;
  bit   go;
  logic e_we_a, e_we_b, e_start, e_busy, e_err;
  int   e_addr;
  logic [DATA_W-1:0] e_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      na = 0; nb = 0; phase = 0;
      e_we_a = 0; e_we_b = 0; e_start = 0; e_busy = 0; e_err = 0;
      e_addr = 0; e_data = '0;
    end else begin
      e_we_a = 0; e_we_b = 0; e_start = 0;
      case (phase)
        0: begin
          go = (na == N) && (nb == N);
          if (a_en && b_en) e_err = 1;
          else if (a_en) begin
            if (na == N) e_err = 1;
            else begin e_we_a = 1; e_addr = na; e_data = data; na++; end
          end else if (b_en) begin
            if (nb == N) e_err = 1;
            else begin e_we_b = 1; e_addr = nb; e_data = data; nb++; end
          end
          if (go) begin phase = 1; e_start = 1; end
        end
        1: phase = 2;
        default: if (done) begin phase = 0; na = 0; nb = 0; end
      endcase
      e_busy = (phase != 0);
    end
  end

  always @(negedge clk) begin
    chk("buf_a_we",   buf_a_we,   e_we_a);
    chk("buf_b_we",   buf_b_we,   e_we_b);
    chk("buf_addr",   buf_addr,   e_addr);
    chk("buf_wdata",  buf_wdata,  e_data);
    chk("mtx_start",  mtx_start,  e_start);
    chk("busy",       busy,       e_busy);
    chk("seq_err",    seq_err,    e_err);
    chk("pipe_stall", pipe_stall, (phase != 0) && (a_en || b_en));
  end

  task automatic drive(input logic a, input logic b, input logic [DATA_W-1:0] d, input logic dn);
    @(posedge clk); #2;
    a_en = a; b_en = b; data = d; done = dn;
  endtask

  task automatic sample;
    @(negedge clk); #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    a_en = 0; b_en = 0; done = 0; reset = 1;
    @(posedge clk); #2;
    reset = 0;
  endtask

  initial begin
    do_reset();
    sample();
    chk("rst_we_a", buf_a_we, 0);
    chk("rst_addr", buf_addr, 0);
    chk("rst_busy", busy, 0);

    // Reset in the middle of a fill
    for (int i = 0; i < 5; i++) drive(1, 0, 100 + i, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("mid_addr4", buf_addr, 4);
    chk("mid_data4", buf_wdata, 104);
    reset = 1; #1;
    chk("async_addr", buf_addr, 0);
    chk("async_data", buf_wdata, 0);
    chk("async_we_a", buf_a_we, 0);
    @(posedge clk); #2; reset = 0;
    drive(1, 0, 55, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("post_rst_we", buf_a_we, 1);
    chk("post_rst_addr", buf_addr, 0);
    chk("post_rst_data", buf_wdata, 55);

    // Full fill of A then B
    do_reset();
    for (int i = 0; i < N; i++) drive(1, 0, i, 0);
    for (int i = 0; i < N; i++) drive(0, 1, i, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("last_b_we", buf_b_we, 1);
    chk("last_b_addr", buf_addr, 15);
    chk("last_b_data", buf_wdata, 15);
    chk("pre_start", mtx_start, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("start_pulse", mtx_start, 1);
    chk("start_busy", busy, 1);
    drive(0, 0, 0, 0);
    sample();
    chk("start_once", mtx_start, 0);
    chk("compute_busy", busy, 1);

    // Load held during COMPUTE, released by mtx_done
    drive(1, 0, 77, 0);
    sample();
    chk("held_stall", pipe_stall, 1);
    chk("held_no_we", buf_a_we, 0);
    drive(1, 0, 77, 1);
    sample();
    chk("held_stall2", pipe_stall, 1);
    drive(1, 0, 77, 0);
    sample();
    chk("idle_no_stall", pipe_stall, 0);
    chk("idle_busy", busy, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("held_we", buf_a_we, 1);
    chk("held_addr", buf_addr, 0);
    chk("held_data", buf_wdata, 77);
    chk("no_err_yet", seq_err, 0);

    // Both enables together
    drive(1, 1, 9, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("both_no_a", buf_a_we, 0);
    chk("both_no_b", buf_b_we, 0);
    chk("both_err", seq_err, 1);

    // mtx_done in IDLE is ignored; counting continues
    do_reset();
    drive(1, 0, 1, 0);
    drive(1, 0, 2, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    sample();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_err", seq_err, 0);
    drive(1, 0, 3, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("idle_done_addr", buf_addr, 2);
    chk("idle_done_data", buf_wdata, 3);

    // 17th A load into a full buffer
    for (int i = 3; i < N; i++) drive(1, 0, i, 0);
    drive(1, 0, 99, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("ovf_no_we", buf_a_we, 0);
    chk("ovf_err", seq_err, 1);
    chk("ovf_addr_hold", buf_addr, 15);
    for (int i = 0; i < N; i++) drive(0, 1, 200 + i, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 0, 42, 0);
    drive(0, 0, 0, 0);
    sample();
    chk("refill_addr", buf_addr, 0);
    chk("refill_data", buf_wdata, 42);
    chk("err_sticky", seq_err, 1);
    repeat (3) drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
